// File: rtl/rpsc_interlock_card.sv
// RPSC card interlock: synchronised/filtered alarm latch plus ground-hold / supply-ramp sequencer.
// Optional first-fault capture is built when RPSC_FIRST_FAULT_EN is defined.
module rpsc_interlock_card #(
   parameter int N_ALARM     = 8,
   parameter int FILT_LEN    = 4,
   parameter int HOLD_CYCLES = 128
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_ALARM-1:0] alarm_i,
   input  logic [N_ALARM-1:0] alarm_mask_i,
   input  logic               ack_i,
   input  logic               ps_ready_i,
   input  logic               ps_act_i,
   input  logic               u_low_i,
   output logic [N_ALARM-1:0] alarm_latched_o,
   output logic               not_alarm_o,
   output logic               ground_hold_ok_o,
   output logic               on_perm_n_o,
   output logic               ps_on_n_o,
   output logic               ps_ok_n_o,
   output logic               u_low_n_o,
   output logic [2:0]         state_o,
   output logic [4:0]         first_fault_o,
   output logic               first_fault_vld_o
);

   localparam int NS = N_ALARM + 3;
   localparam int NF = N_ALARM + 1;
   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_SAT  = CW'(HOLD_CYCLES);
   localparam logic [NF-1:0] FILT_RST  = {1'b0, {N_ALARM{1'b1}}};

   typedef enum logic [2:0] {
      ST_FAULT = 3'd0,
      ST_IDLE  = 3'd1,
      ST_ARMED = 3'd2,
      ST_RAMP  = 3'd3,
      ST_RUN   = 3'd4
   } state_t;

   logic [NS-1:0]          sync1_d, sync1_q, sync2_d, sync2_q;
   logic [NF-1:0]          filt_d, filt_q;
   logic [NF-1:0][FW-1:0]  filt_cnt_d, filt_cnt_q;
   logic [N_ALARM-1:0]     latched_d, latched_q;
   logic                   not_alarm_d, not_alarm_q;
   state_t                 state_d, state_q;
   logic [CW-1:0]          hold_cnt_d, hold_cnt_q;
   logic                   ghok_d, ghok_q;
   logic                   on_perm_n_d, on_perm_n_q;
   logic                   ps_ok_n_d, ps_ok_n_q;
   logic                   u_low_n_d, u_low_n_q;

   logic [N_ALARM-1:0]     alarm_filt;
   logic                   ps_act_filt, ps_ready_sync, u_low_sync;

   // Sync bit layout: [N-1:0] alarms, [N] ps_act, [N+1] ps_ready, [N+2] u_low
   always_comb begin
      sync1_d = {u_low_i, ps_ready_i, ps_act_i, alarm_i};
      sync2_d = sync1_q;
   end

   assign alarm_filt    = filt_q[N_ALARM-1:0];
   assign ps_act_filt   = filt_q[N_ALARM];
   assign ps_ready_sync = sync2_q[N_ALARM+1];
   assign u_low_sync    = sync2_q[N_ALARM+2];

   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      for (int i = 0; i < NF; i++) begin
         if (sync2_q[i] != filt_q[i]) begin
            if (filt_cnt_q[i] == FILT_LAST) begin
               filt_d[i] = ~filt_q[i];
            end else begin
               filt_cnt_d[i] = filt_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Set term is OR-ed last so a live fault wins over a simultaneous ack
   always_comb begin
      latched_d   = (latched_q & ~({N_ALARM{ack_i}} & ~alarm_filt)) | (alarm_filt & ~alarm_mask_i);
      not_alarm_d = ~|latched_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         filt_q      <= FILT_RST;
         filt_cnt_q  <= '0;
         latched_q   <= '1;
         not_alarm_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
         latched_q   <= latched_d;
         not_alarm_q <= not_alarm_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_FAULT;
         hold_cnt_q  <= '0;
         ghok_q      <= 1'b0;
         on_perm_n_q <= 1'b1;
         ps_ok_n_q   <= 1'b1;
         u_low_n_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         ghok_q      <= ghok_d;
         on_perm_n_q <= on_perm_n_d;
         ps_ok_n_q   <= ps_ok_n_d;
         u_low_n_q   <= u_low_n_d;
      end
   end

   // Hold counter only advances while staying in RAMP; every other path leaves it at zero
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = '0;
      if (|latched_q) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_FAULT: state_d = ST_IDLE;
            ST_IDLE:  if (ps_ready_sync) state_d = ST_ARMED;
            ST_ARMED: begin
               if (!ps_ready_sync)   state_d = ST_IDLE;
               else if (ps_act_filt) state_d = ST_RAMP;
            end
            ST_RAMP: begin
               if (!ps_ready_sync)              state_d = ST_IDLE;
               else if (!ps_act_filt)           state_d = ST_ARMED;
               else if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
               else hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;
            end
            ST_RUN: begin
               if (!ps_ready_sync)     state_d = ST_IDLE;
               else if (!ps_act_filt)  state_d = ST_ARMED;
            end
            default: state_d = ST_FAULT;
         endcase
      end
   end

   // Decoded from the next state and registered, so outputs change with state_o and never glitch
   always_comb begin
      ghok_d      = (state_d == ST_ARMED) || (state_d == ST_RAMP) || (state_d == ST_RUN);
      on_perm_n_d = ~ghok_d;
      ps_ok_n_d   = (state_d != ST_RUN);
      u_low_n_d   = ~((state_d == ST_RUN) && u_low_sync);
   end

   assign alarm_latched_o  = latched_q;
   assign not_alarm_o      = not_alarm_q;
   assign ground_hold_ok_o = ghok_q;
   assign on_perm_n_o      = on_perm_n_q;
   assign ps_on_n_o        = ~ps_act_filt;
   assign ps_ok_n_o        = ps_ok_n_q;
   assign u_low_n_o        = u_low_n_q;
   assign state_o          = state_q;

`ifdef RPSC_FIRST_FAULT_EN
   logic [4:0] first_fault_d, first_fault_q;
   logic       ff_vld_d, ff_vld_q;

   function automatic logic [4:0] lowest_set(input logic [N_ALARM-1:0] v);
      lowest_set = '0;
      for (int i = N_ALARM - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = 5'(i);
      end
   endfunction

   // Capture only on a 0 -> non-zero transition, so the power-up all-ones latch never qualifies
   always_comb begin
      first_fault_d = first_fault_q;
      ff_vld_d      = ff_vld_q;
      if (latched_d == '0) begin
         first_fault_d = '0;
         ff_vld_d      = 1'b0;
      end else if (latched_q == '0) begin
         first_fault_d = lowest_set(latched_d);
         ff_vld_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         first_fault_q <= '0;
         ff_vld_q      <= 1'b0;
      end else begin
         first_fault_q <= first_fault_d;
         ff_vld_q      <= ff_vld_d;
      end
   end

   assign first_fault_o     = first_fault_q;
   assign first_fault_vld_o = ff_vld_q;
`else
   assign first_fault_o     = 5'd0;
   assign first_fault_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_rpsc_interlock_card.sv
// Scoreboard bench for rpsc_interlock_card (N_ALARM=8, FILT_LEN=4, HOLD_CYCLES=128).
// First-fault checks follow RPSC_FIRST_FAULT_EN the same way the design does.
module tb_rpsc_interlock_card;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] alarm_i, alarm_mask_i;
   logic         ack_i, ps_ready_i, ps_act_i, u_low_i;
   logic [N-1:0] alarm_latched_o;
   logic         not_alarm_o, ground_hold_ok_o, on_perm_n_o, ps_on_n_o, ps_ok_n_o, u_low_n_o;
   logic [2:0]   state_o;
   logic [4:0]   first_fault_o;
   logic         first_fault_vld_o;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc;

   rpsc_interlock_card #(.N_ALARM(N), .FILT_LEN(4), .HOLD_CYCLES(128)) dut (
      .clk               (clk),
      .reset             (reset),
      .alarm_i           (alarm_i),
      .alarm_mask_i      (alarm_mask_i),
      .ack_i             (ack_i),
      .ps_ready_i        (ps_ready_i),
      .ps_act_i          (ps_act_i),
      .u_low_i           (u_low_i),
      .alarm_latched_o   (alarm_latched_o),
      .not_alarm_o       (not_alarm_o),
      .ground_hold_ok_o  (ground_hold_ok_o),
      .on_perm_n_o       (on_perm_n_o),
      .ps_on_n_o         (ps_on_n_o),
      .ps_ok_n_o         (ps_ok_n_o),
      .u_low_n_o         (u_low_n_o),
      .state_o           (state_o),
      .first_fault_o     (first_fault_o),
      .first_fault_vld_o (first_fault_vld_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_underflow: got 0x%0h with no expectation queued", obs);
      end else begin
         e = sb_q.pop_front();
         check_eq(e.tag, obs, e.val);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] target, input int bound, output int cycles);
      cycles = 0;
      while (state_o !== target && cycles < bound) begin
         tick();
         cycles++;
      end
      sb_pop(32'(state_o));
   endtask

   task automatic push_reset_vals();
      sb_push("rst_state", 32'd0);
      sb_push("rst_latched", 32'hFF);
      sb_push("rst_not_alarm", 32'd0);
      sb_push("rst_ghok", 32'd0);
      sb_push("rst_on_perm_n", 32'd1);
      sb_push("rst_ps_on_n", 32'd1);
      sb_push("rst_ps_ok_n", 32'd1);
      sb_push("rst_u_low_n", 32'd1);
      sb_push("rst_ff_vld", 32'd0);
   endtask

   task automatic pop_reset_vals();
      sb_pop(32'(state_o));
      sb_pop(32'(alarm_latched_o));
      sb_pop(32'(not_alarm_o));
      sb_pop(32'(ground_hold_ok_o));
      sb_pop(32'(on_perm_n_o));
      sb_pop(32'(ps_on_n_o));
      sb_pop(32'(ps_ok_n_o));
      sb_pop(32'(u_low_n_o));
      sb_pop(32'(first_fault_vld_o));
   endtask

   task automatic ack_pulse();
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      alarm_i      = '0;
      alarm_mask_i = '0;
      ack_i        = 1'b0;
      ps_ready_i   = 1'b0;
      ps_act_i     = 1'b0;
      u_low_i      = 1'b0;

      // Power-up: reset values, then one ack with clean inputs
      push_reset_vals();
      tick(3);
      pop_reset_vals();
      reset = 1'b1;
      sb_push("pwr_latched_held", 32'hFF);
      tick(10);
      sb_pop(32'(alarm_latched_o));
      sb_push("pwr_latched_cleared", 32'd0);
      sb_push("pwr_state_idle", 32'd1);
      sb_push("pwr_not_alarm", 32'd1);
      ack_pulse();
      sb_pop(32'(alarm_latched_o));
      tick();
      sb_pop(32'(state_o));
      sb_pop(32'(not_alarm_o));

      // Filter: 3-cycle pulse rejected
      sb_push("short_pulse_latched", 32'd0);
      sb_push("short_pulse_state", 32'd1);
      alarm_i = 8'h04;
      tick(3);
      alarm_i = 8'h00;
      tick(10);
      sb_pop(32'(alarm_latched_o));
      sb_pop(32'(state_o));

      // Filter: 5-cycle pulse latches at edge 7, FAULT at edge 8
      sb_push("pulse_edge6_latched", 32'd0);
      sb_push("pulse_edge7_latched", 32'h04);
      sb_push("pulse_edge7_state", 32'd1);
      sb_push("pulse_edge8_state", 32'd0);
      sb_push("pulse_edge8_not_alarm", 32'd0);
      alarm_i = 8'h04;
      tick(5);
      alarm_i = 8'h00;
      tick();
      sb_pop(32'(alarm_latched_o));
      tick();
      sb_pop(32'(alarm_latched_o));
      sb_pop(32'(state_o));
`ifdef RPSC_FIRST_FAULT_EN
      check_eq("pulse_first_fault", 32'(first_fault_o), 32'd2);
      check_eq("pulse_first_fault_vld", 32'(first_fault_vld_o), 32'd1);
`endif
      tick();
      sb_pop(32'(state_o));
      sb_pop(32'(not_alarm_o));
      tick(10);
      sb_push("pulse_ack_state", 32'd1);
      ack_pulse();
      tick();
      sb_pop(32'(state_o));

      // Sequence up to RUN
      ps_ready_i = 1'b1;
      ps_act_i   = 1'b1;
      sb_push("seq_armed", 32'd2);
      sb_push("seq_armed_latency", 32'd3);
      sb_push("seq_armed_ghok", 32'd1);
      sb_push("seq_ramp", 32'd3);
      sb_push("seq_ramp_latency", 32'd4);
      sb_push("seq_ramp_ps_on_n", 32'd0);
      sb_push("seq_ramp_ps_ok_n", 32'd1);
      sb_push("seq_run", 32'd4);
      sb_push("seq_run_hold", 32'd128);
      wait_state(3'd2, 20, cyc);
      sb_pop(32'(cyc));
      sb_pop(32'(ground_hold_ok_o));
      wait_state(3'd3, 20, cyc);
      sb_pop(32'(cyc));
      sb_pop(32'(ps_on_n_o));
      sb_pop(32'(ps_ok_n_o));
      wait_state(3'd4, 200, cyc);
      sb_pop(32'(cyc));
      check_eq("run_ps_ok_n", 32'(ps_ok_n_o), 32'd0);
      check_eq("run_on_perm_n", 32'(on_perm_n_o), 32'd0);
      check_eq("run_u_low_n_idle", 32'(u_low_n_o), 32'd1);
      sb_push("ulow_edge2", 32'd1);
      sb_push("ulow_edge3", 32'd0);
      u_low_i = 1'b1;
      tick(2);
      sb_pop(32'(u_low_n_o));
      tick();
      sb_pop(32'(u_low_n_o));
      u_low_i = 1'b0;

      // Abort at RAMP count 60, then a full hold again
      ps_act_i = 1'b0;
      sb_push("abort_run_to_armed", 32'd2);
      wait_state(3'd2, 20, cyc);
      ps_act_i = 1'b1;
      sb_push("abort_ramp_reentry", 32'd3);
      wait_state(3'd3, 20, cyc);
      tick(60);
      ps_act_i = 1'b0;
      sb_push("abort_armed", 32'd2);
      sb_push("abort_latency", 32'd7);
      wait_state(3'd2, 20, cyc);
      sb_pop(32'(cyc));
      ps_act_i = 1'b1;
      sb_push("abort_ramp_again", 32'd3);
      sb_push("abort_run", 32'd4);
      sb_push("abort_full_hold", 32'd128);
      wait_state(3'd3, 20, cyc);
      wait_state(3'd4, 200, cyc);
      sb_pop(32'(cyc));

      // Alarm in RUN: bit 0 masked, bit 5 live
      alarm_mask_i = 8'h01;
      alarm_i      = 8'h21;
      sb_push("run_alarm_latched", 32'h20);
      sb_push("run_alarm_state_e7", 32'd4);
      sb_push("run_alarm_fault", 32'd0);
      sb_push("run_alarm_ps_ok_n", 32'd1);
      sb_push("run_alarm_ghok", 32'd0);
      sb_push("ack_while_high_latched", 32'h20);
      sb_push("ack_while_high_state", 32'd0);
      tick(7);
      sb_pop(32'(alarm_latched_o));
      sb_pop(32'(state_o));
`ifdef RPSC_FIRST_FAULT_EN
      check_eq("run_first_fault", 32'(first_fault_o), 32'd5);
      check_eq("run_first_fault_vld", 32'(first_fault_vld_o), 32'd1);
`else
      check_eq("off_first_fault", 32'(first_fault_o), 32'd0);
      check_eq("off_first_fault_vld", 32'(first_fault_vld_o), 32'd0);
`endif
      tick();
      sb_pop(32'(state_o));
      sb_pop(32'(ps_ok_n_o));
      sb_pop(32'(ground_hold_ok_o));
      ack_pulse();
      sb_pop(32'(alarm_latched_o));
      sb_pop(32'(state_o));
      alarm_i = 8'h00;
      tick(12);
      sb_push("clear_ack_latched", 32'd0);
      sb_push("clear_ack_idle", 32'd1);
      ack_pulse();
      sb_pop(32'(alarm_latched_o));
      tick();
      sb_pop(32'(state_o));
`ifdef RPSC_FIRST_FAULT_EN
      check_eq("clear_first_fault_vld", 32'(first_fault_vld_o), 32'd0);
`endif

      // Asynchronous reset in the middle of RAMP
      sb_push("mid_ramp_state", 32'd3);
      wait_state(3'd3, 30, cyc);
      tick(20);
      push_reset_vals();
      #2;
      reset = 1'b0;
      #1;
      pop_reset_vals();
      tick(2);

      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL sb_leftover: got %0d unchecked expectations required 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
